// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Width of the divider latency down-counter (covers DIV_CYCLES up to 63).
    localparam int CNT_W = 6;

    // Default divider latency in cycles after the start pulse.
    localparam int DIV_CYCLES_DEFAULT = 4;

    // Sequencer states: RUN for normal flow, DIV while the iterative divider works.
    typedef enum logic {
        RUN = 1'b0,
        DIV = 1'b1
    } state_e;

    // Decrement that stops at zero, used while a memory wait freezes the divide exit.
    function automatic logic [CNT_W-1:0] cnt_dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: 32-bit saturating event counter with enable and active-low sync reset.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    // Count enabled cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the five-stage pipeline.
// Merges exception, data-memory wait, divider sequencing, load-use and branch
// requests into per-stage write-enables and bubble controls.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters;
// without it stall_cnt and flush_cnt are constant zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_use_stall,
    input  logic        div_EXE,
    input  logic        mem_req_MEM,
    input  logic        mem_ack,
    input  logic        br_taken_ID,
    input  logic        exc_WB,
    output logic        div_start,
    output logic        div_busy,
    output logic        div_cancel,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EXE_Write,
    output logic        EXE_MEM_Write,
    output logic        MEM_WB_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EXE_Flush,
    output logic        EXE_MEM_Flush,
    output logic        MEM_WB_Flush,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // The start cycle itself is the first stall cycle, so DIV holds DIV_CYCLES-1 more.
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic mem_wait;
    logic in_div;
    logic cnt_zero;

    assign mem_wait = mem_req_MEM & ~mem_ack;
    assign in_div   = (state_q == DIV);
    assign cnt_zero = (cnt_q == '0);

    // Sequencer state and divider latency counter, highest-priority event first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (exc_WB) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (mem_wait) begin
            // Divider keeps running underneath, but DIV is not left until memory answers.
            if (in_div) begin
                cnt_q <= cnt_dec_sat(cnt_q);
            end
        end else if (in_div) begin
            if (cnt_zero) begin
                state_q <= RUN;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else if (div_EXE) begin
            state_q <= DIV;
            cnt_q   <= DIV_LOAD;
        end
    end

    // Per-stage write/flush decode from state, counter and current requests.
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EXE_Write  = 1'b1;
        EXE_MEM_Write = 1'b1;
        MEM_WB_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EXE_Flush  = 1'b0;
        EXE_MEM_Flush = 1'b0;
        MEM_WB_Flush  = 1'b0;
        div_start     = 1'b0;
        div_busy      = 1'b0;
        div_cancel    = 1'b0;

        if (!rst) begin
            // Reset loads bubbles everywhere; divider flags drop immediately.
            IF_ID_Flush   = 1'b1;
            ID_EXE_Flush  = 1'b1;
            EXE_MEM_Flush = 1'b1;
            MEM_WB_Flush  = 1'b1;
        end else begin
            div_busy = in_div;
            if (exc_WB) begin
                // PC still loads so the externally selected handler vector is taken.
                IF_ID_Flush   = 1'b1;
                ID_EXE_Flush  = 1'b1;
                EXE_MEM_Flush = 1'b1;
                MEM_WB_Flush  = 1'b1;
                div_cancel    = in_div;
            end else if (mem_wait) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EXE_Write  = 1'b0;
                EXE_MEM_Write = 1'b0;
                MEM_WB_Flush  = 1'b1;
            end else if (in_div && !cnt_zero) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EXE_Write  = 1'b0;
                EXE_MEM_Flush = 1'b1;
            end else if (!in_div && div_EXE) begin
                div_start     = 1'b1;
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EXE_Write  = 1'b0;
                EXE_MEM_Flush = 1'b1;
            end else if (!in_div && ld_use_stall) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EXE_Flush  = 1'b1;
            end else if (br_taken_ID) begin
                // Reached only when nothing stalls, including the divide release cycle.
                IF_ID_Flush   = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [1:0]       perf_en;
    logic [1:0][31:0] perf_val;

    assign perf_en = {exc_WB, ~PCWrite};

    // Index 0 counts PC-stall cycles, index 1 counts exception flushes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            pipe_perf_cnt u_cnt (
                .clk     (clk),
                .rst_n_i (rst),
                .en_i    (perf_en[gi]),
                .cnt_o   (perf_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = perf_val[0];
    assign flush_cnt = perf_val[1];
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus multi-cycle sequences for pipe_ctrl.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_use_stall, div_EXE, mem_req_MEM, mem_ack, br_taken_ID, exc_WB;
    logic        div_start, div_busy, div_cancel;
    logic        PCWrite, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write, MEM_WB_Write;
    logic        IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush;
    logic [31:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.DIV_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_use_stall  (ld_use_stall),
        .div_EXE       (div_EXE),
        .mem_req_MEM   (mem_req_MEM),
        .mem_ack       (mem_ack),
        .br_taken_ID   (br_taken_ID),
        .exc_WB        (exc_WB),
        .div_start     (div_start),
        .div_busy      (div_busy),
        .div_cancel    (div_cancel),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .ID_EXE_Write  (ID_EXE_Write),
        .EXE_MEM_Write (EXE_MEM_Write),
        .MEM_WB_Write  (MEM_WB_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EXE_Flush  (ID_EXE_Flush),
        .EXE_MEM_Flush (EXE_MEM_Flush),
        .MEM_WB_Flush  (MEM_WB_Flush),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    // Output bundle: {start,busy,cancel, PCW,IFIDW,IDEXW,EXMEMW,MEMWBW, IFIDF,IDEXF,EXMEMF,MEMWBF}
    logic [11:0] outs;
    assign outs = {div_start, div_busy, div_cancel,
                   PCWrite, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write, MEM_WB_Write,
                   IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush};

    localparam logic [11:0] O_IDLE   = 12'b000_11111_0000;
    localparam logic [11:0] O_BR     = 12'b000_11111_1000;
    localparam logic [11:0] O_LDU    = 12'b000_00111_0100;
    localparam logic [11:0] O_ALLFL  = 12'b000_11111_1111;
    localparam logic [11:0] O_MWAIT  = 12'b000_00001_0001;
    localparam logic [11:0] O_DSTART = 12'b100_00011_0010;
    localparam logic [11:0] O_DSTALL = 12'b010_00011_0010;
    localparam logic [11:0] O_DREL   = 12'b010_11111_0000;
    localparam logic [11:0] O_DWAIT  = 12'b010_00001_0001;
    localparam logic [11:0] O_DEXC   = 12'b011_11111_1111;

    // Input bundle: {exc, mem_req, mem_ack, div, ld_use, br}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_BR   = 6'b000001;
    localparam logic [5:0] I_LD   = 6'b000010;
    localparam logic [5:0] I_DIV  = 6'b000100;
    localparam logic [5:0] I_ACK  = 6'b001000;
    localparam logic [5:0] I_REQ  = 6'b010000;
    localparam logic [5:0] I_EXC  = 6'b100000;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] EXP_STALLS = 32'd10;
    localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    typedef struct {
        logic [5:0]  in;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and let the decode settle.
    task automatic cyc(input logic [5:0] in);
        @(negedge clk);
        {exc_WB, mem_req_MEM, mem_ack, div_EXE, ld_use_stall, br_taken_ID} = in;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {exc_WB, mem_req_MEM, mem_ack, div_EXE, ld_use_stall, br_taken_ID} = I_NONE;

        vecs[0]  = '{I_NONE,                      O_IDLE};
        vecs[1]  = '{I_BR,                        O_BR};
        vecs[2]  = '{I_LD,                        O_LDU};
        vecs[3]  = '{I_LD | I_BR,                 O_LDU};
        vecs[4]  = '{I_DIV,                       O_DSTART};
        vecs[5]  = '{I_DIV | I_LD | I_BR,         O_DSTART};
        vecs[6]  = '{I_REQ,                       O_MWAIT};
        vecs[7]  = '{I_REQ | I_ACK,               O_IDLE};
        vecs[8]  = '{I_REQ | I_DIV | I_LD | I_BR, O_MWAIT};
        vecs[9]  = '{I_EXC,                       O_ALLFL};
        vecs[10] = '{I_EXC | I_REQ | I_DIV | I_LD | I_BR, O_ALLFL};
        vecs[11] = '{I_REQ | I_ACK | I_BR,        O_BR};
        vecs[12] = '{I_ACK | I_LD,                O_LDU};

        // Reset held for two rising edges.
        @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outs", 32'(outs), 32'(O_ALLFL));
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_flush_cnt", flush_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_reset_outs", 32'(outs), 32'(O_IDLE));

        // Single-cycle decode in RUN; inputs cleared before the next edge so state stays RUN.
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].in);
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            #1;
            {exc_WB, mem_req_MEM, mem_ack, div_EXE, ld_use_stall, br_taken_ID} = I_NONE;
        end

        // Divide, latency 4: start, three DIV stall cycles, then release.
        cyc(I_DIV); chk("div_start_cyc", 32'(outs), 32'(O_DSTART));
        for (int i = 0; i < 3; i++) begin
            cyc(I_DIV); chk($sformatf("div_stall%0d", i), 32'(outs), 32'(O_DSTALL));
        end
        cyc(I_DIV); chk("div_release", 32'(outs), 32'(O_DREL));
        cyc(I_NONE); chk("div_back_run", 32'(outs), 32'(O_IDLE));

        // Load-use suppresses a branch, which then goes through the next cycle.
        cyc(I_LD | I_BR); chk("ldu_br_stall", 32'(outs), 32'(O_LDU));
        cyc(I_BR);        chk("ldu_br_retry", 32'(outs), 32'(O_BR));

        // Memory wait from cnt=1 for three cycles holds DIV at cnt=0 until mem_ack.
        cyc(I_DIV);         chk("dm_start", 32'(outs), 32'(O_DSTART));
        cyc(I_DIV);         chk("dm_cnt3", 32'(outs), 32'(O_DSTALL));
        cyc(I_DIV);         chk("dm_cnt2", 32'(outs), 32'(O_DSTALL));
        for (int i = 0; i < 3; i++) begin
            cyc(I_DIV | I_REQ); chk($sformatf("dm_wait%0d", i), 32'(outs), 32'(O_DWAIT));
        end
        cyc(I_DIV | I_REQ | I_ACK); chk("dm_release", 32'(outs), 32'(O_DREL));
        cyc(I_NONE);                chk("dm_back_run", 32'(outs), 32'(O_IDLE));

        // Exception in DIV at cnt=2 cancels the divide.
        cyc(I_DIV);         chk("de_start", 32'(outs), 32'(O_DSTART));
        cyc(I_DIV);         chk("de_cnt3", 32'(outs), 32'(O_DSTALL));
        cyc(I_DIV | I_EXC); chk("de_exc", 32'(outs), 32'(O_DEXC));
        cyc(I_NONE);        chk("de_back_run", 32'(outs), 32'(O_IDLE));

        // Reset mid-divide drops busy at once without a cancel.
        cyc(I_DIV); chk("dr_start", 32'(outs), 32'(O_DSTART));
        cyc(I_DIV); chk("dr_stall", 32'(outs), 32'(O_DSTALL));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("dr_reset", 32'(outs), 32'(O_ALLFL));
        @(posedge clk);
        @(negedge clk);
        {exc_WB, mem_req_MEM, mem_ack, div_EXE, ld_use_stall, br_taken_ID} = I_NONE;
        #1;
        chk("dr_stall_cnt_clr", stall_cnt, 32'd0);
        chk("dr_flush_cnt_clr", flush_cnt, 32'd0);
        rst = 1'b1;
        #1;
        chk("dr_post_reset", 32'(outs), 32'(O_IDLE));

        // Perf counters: ten load-use stalls and two exceptions.
        for (int i = 0; i < 10; i++) cyc(I_LD);
        for (int i = 0; i < 2; i++) cyc(I_EXC);
        cyc(I_NONE);
        chk("perf_stall_cnt", stall_cnt, EXP_STALLS);
        chk("perf_flush_cnt", flush_cnt, EXP_FLUSHES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five-stage pipeline. It merges the load-use stall from the hazard/bypass logic, the MEM-stage data-memory handshake, taken-branch redirects and WB-stage exceptions into one set of per-stage register write-enables and flush (bubble) controls. It also sequences the iterative divider in EXE by issuing its start pulse and counting its fixed latency. It sits beside the ID-stage hazard unit and drives the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers and the PC.

## Interface
- DIV_CYCLES, 4: divider latency in cycles after start; legal range 1..63.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- ld_use_stall  in  1  load-use hazard request from the ID-stage hazard unit.
- div_EXE  in  1  the instruction in EXE is DIV/DIVU.
- mem_req_MEM  in  1  the instruction in MEM performs a data-memory access.
- mem_ack  in  1  data memory completes the access this cycle.
- br_taken_ID  in  1  taken branch/jump resolved in ID.
- exc_WB  in  1  exception committed in WB.
- div_start  out  1  one-cycle divider start pulse.
- div_busy  out  1  divider sequence in progress.
- div_cancel  out  1  abort the running divide.
- PCWrite, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write, MEM_WB_Write  out  1 each  register load enables.
- IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush  out  1 each  load a bubble into that register.
- stall_cnt  out  32  PC-stall cycle count (perf).
- flush_cnt  out  32  exception flush count (perf).

## Operation
- FSM states: RUN, DIV. Registered 6-bit down-counter cnt.
- Default, nothing active: all Write=1, all Flush=0.
- Priority per cycle, highest first: exception > memory wait > divide > load-use > branch.
- Exception (exc_WB=1), any state:
  - All Write=1 and all Flush=1; PCWrite=1, with the handler vector selected externally.
  - div_cancel=1 if state=DIV.
  - Next state RUN, cnt<=0.
- Memory wait (mem_req_MEM & ~mem_ack):
  - PCWrite, IF_ID_Write, ID_EXE_Write and EXE_MEM_Write are 0; MEM_WB_Flush=1.
  - Divider counter keeps decrementing to 0 and then holds.
  - FSM does not leave DIV until the wait ends.
- Divide in RUN (div_EXE=1):
  - div_start=1; PCWrite, IF_ID_Write and ID_EXE_Write are 0; EXE_MEM_Flush=1.
  - cnt<=DIV_CYCLES-1; next state DIV.
- State DIV:
  - div_busy=1.
  - cnt≠0: same stall pattern as divide start, cnt decrements.
  - cnt=0 with no memory wait: all Write=1 and the quotient leaves EXE; next state RUN.
  - div_start is never reasserted in DIV.
- Load-use, RUN only, no divide: PCWrite=0, IF_ID_Write=0, ID_EXE_Flush=1.
- Branch: IF_ID_Flush=1 only when no higher-priority event occurs. If stalled, the branch is suppressed and re-presented next cycle.

## Timing
- All outputs are combinational from state, cnt and inputs; no input-to-output registering.
- Divide: EXE is occupied for DIV_CYCLES+1 cycles; PCWrite is low for DIV_CYCLES cycles.
- Reset (rst=0):
  - State RUN, cnt=0.
  - All Write=1 and all Flush=1.
  - div_start, div_busy and div_cancel are 0; counters are 0.
  - Reset mid-divide drops div_busy the same cycle, without a div_cancel pulse.
- Memory wait overlapping the last DIV cycle extends DIV until mem_ack arrives.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt increments on every cycle with PCWrite=0.
  - flush_cnt increments on every exc_WB cycle.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

## Structure
- Package pipe_ctrl_pkg holds:
  - state encoding (RUN=1'b0, DIV=1'b1);
  - DIV_CYCLES default;
  - counter width constant (6).
- One sub-module, pipe_perf_cnt: a saturating 32-bit counter with enable, instantiated twice under PIPE_CTRL_PERF_EN.

## Test plan
- rst=0 for 2 cycles, then rst=1: all Flush=1 during reset, then 0; div_busy=0, stall_cnt=0.
- div_EXE=1, DIV_CYCLES=4: div_start high for 1 cycle; PCWrite=0 and EXE_MEM_Flush=1 for 4 cycles; all Write=1 in cycle 5; state back to RUN.
- ld_use_stall=1 with br_taken_ID=1: PCWrite=0, ID_EXE_Flush=1, IF_ID_Flush=0; next cycle with ld_use_stall=0, IF_ID_Flush=1.
- Divide started, mem_req_MEM=1 and mem_ack low from DIV cnt=1 for 3 cycles: MEM_WB_Flush=1 throughout; DIV is held at cnt=0; release on the mem_ack cycle.
- exc_WB=1 in DIV at cnt=2: div_cancel=1, all Flush=1, PCWrite=1; next cycle state RUN and div_busy=0.
- PIPE_CTRL_PERF_EN defined: 10 load-use cycles plus 2 exceptions give stall_cnt=10 and flush_cnt=2. Without the macro, both read 0.
